// File: rtl/udma_pkg.sv
// rtl/udma_pkg.sv - shared uDMA channel types, datasize encodings and TX prefetch states
package udma_pkg;

  localparam int UDMA_DATA_W = 32;
  localparam int UDMA_DEST_W = 5;

  typedef logic [UDMA_DATA_W-1:0] ch_data_t;
  typedef logic [1:0]             ch_datasize_t;
  typedef logic [UDMA_DEST_W-1:0] ch_dest_t;

  localparam ch_datasize_t UDMA_SIZE_BYTE = 2'd0;
  localparam ch_datasize_t UDMA_SIZE_HALF = 2'd1;
  localparam ch_datasize_t UDMA_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_ACTIVE = 2'd1,
    TX_DRAIN  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/udma_prefetch_fifo.sv
// rtl/udma_prefetch_fifo.sv - first-word fall-through FIFO with flush, push, pop and level
module udma_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = pop_i && (level_q != '0);
    // flush beats any concurrent push or pop
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign valid_o = (level_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/udma_tx_prefetch.sv
// rtl/udma_tx_prefetch.sv - uDMA TX channel front end: credit-bounded read prefetch into a local FIFO
module udma_tx_prefetch
  import udma_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
  input  ch_datasize_t          cfg_datasize_i,
  input  ch_dest_t              cfg_destination_i,
  input  logic                  ch_en_i,
  output logic                  ch_req_o,
  input  logic                  ch_gnt_i,
  input  logic                  ch_valid_i,
  input  logic [DATA_WIDTH-1:0] ch_data_i,
  output logic                  ch_ready_o,
  output ch_datasize_t          ch_datasize_o,
  output ch_dest_t              ch_destination_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [CNT_W-1:0]      fifo_level_o,
  output logic                  busy_o
);

  localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W+1)'(DEPTH);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] out_q, out_d;
  ch_datasize_t     dsz_q, dsz_d;
  ch_dest_t         dst_q, dst_d;
  logic [CNT_W-1:0] fifo_level;
  logic [CNT_W:0]   used;
  logic             gnt_fire, ret_fire, push;

  always_comb begin
    // level + outstanding is the credit already spent
    used       = {1'b0, fifo_level} + {1'b0, out_q};
    ch_req_o   = (state_q == TX_ACTIVE) && cfg_en_i && ch_en_i && !cfg_clr_i && (used < DEPTH_CNT);
    ch_ready_o = (state_q != TX_IDLE) && (out_q != '0);
    gnt_fire   = ch_req_o && ch_gnt_i;
    ret_fire   = ch_valid_i && ch_ready_o;
    push       = ret_fire && (state_q == TX_ACTIVE) && !cfg_clr_i;
    out_d      = out_q + CNT_W'(gnt_fire) - CNT_W'(ret_fire);

    state_d = state_q;
    dsz_d   = dsz_q;
    dst_d   = dst_q;
    case (state_q)
      TX_IDLE: begin
        if (cfg_clr_i) begin
          state_d = (out_q != '0) ? TX_DRAIN : TX_IDLE;
        end else if (cfg_en_i) begin
          state_d = TX_ACTIVE;
          dsz_d   = cfg_datasize_i;
          dst_d   = cfg_destination_i;
        end
      end
      TX_ACTIVE: begin
        if (cfg_clr_i)                       state_d = TX_DRAIN;
        else if (!cfg_en_i && out_q == '0)   state_d = TX_IDLE;
      end
      TX_DRAIN: begin
        if (cfg_clr_i)                       state_d = TX_DRAIN;
        else if (out_d == '0)                state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      out_q   <= '0;
      dsz_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dsz_q   <= dsz_d;
      dst_q   <= dst_d;
    end
  end

  udma_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (cfg_clr_i),
    .push_i      (push),
    .push_data_i (ch_data_i),
    .pop_i       (tx_ready_i),
    .head_o      (tx_data_o),
    .valid_o     (tx_valid_o),
    .level_o     (fifo_level)
  );

  assign fifo_level_o     = fifo_level;
  assign ch_datasize_o    = dsz_q;
  assign ch_destination_o = dst_q;
  assign busy_o           = (state_q != TX_IDLE) || (fifo_level != '0);

endmodule
